// File: rtl/perf_pkg.sv
// Shared types and defaults for the performance counter bank.
package perf_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    CLEAR  = 2'd2
  } perf_state_e;

  localparam int NUM_EVT_DEF = 4;
  localparam int CNT_W_DEF   = 32;
  localparam int RD_SEL_W    = 5;

endpackage

// File: rtl/perf_counter_bank_if.sv
// Bundle of the counter bank's control, read and display signals.
interface perf_counter_bank_if #(
  parameter int NUM_EVT = perf_pkg::NUM_EVT_DEF,
  parameter int CNT_W   = perf_pkg::CNT_W_DEF
);

  logic [NUM_EVT-1:0]            evt_i;
  logic                          halt_req_i;
  logic                          resume_i;
  logic                          clr_i;
  logic                          snap_i;
  logic                          disp_we_i;
  logic [31:0]                   disp_data_i;
  logic                          rd_req_i;
  logic [perf_pkg::RD_SEL_W-1:0] rd_sel_i;
  logic                          rd_ack_o;
  logic [CNT_W-1:0]              rd_data_o;
  logic [NUM_EVT:0]              ovf_o;
  logic [31:0]                   disp_o;
  logic                          halt_o;

  modport master (
    output evt_i, halt_req_i, resume_i, clr_i, snap_i,
    output disp_we_i, disp_data_i, rd_req_i, rd_sel_i,
    input  rd_ack_o, rd_data_o, ovf_o, disp_o, halt_o
  );

  modport slave (
    input  evt_i, halt_req_i, resume_i, clr_i, snap_i,
    input  disp_we_i, disp_data_i, rd_req_i, rd_sel_i,
    output rd_ack_o, rd_data_o, ovf_o, disp_o, halt_o
  );

endinterface

// File: rtl/perf_counter.sv
// Single counter with clear, wrap-or-saturate and sticky overflow.
module perf_counter #(
  parameter int CNT_W    = 32,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (&cnt) begin
        ovf <= 1'b1;
        if (SATURATE == 0) cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Event + cycle counter bank with halt/clear FSM, read port and display.
// Define PERF_SNAPSHOT_EN to add shadow registers captured by snap_i.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_EVT  = NUM_EVT_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int SATURATE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_EVT-1:0]  evt_i,
  input  logic                halt_req_i,
  input  logic                resume_i,
  input  logic                clr_i,
  input  logic                snap_i,
  input  logic                disp_we_i,
  input  logic [31:0]         disp_data_i,
  input  logic                rd_req_i,
  input  logic [RD_SEL_W-1:0] rd_sel_i,
  output logic                rd_ack_o,
  output logic [CNT_W-1:0]    rd_data_o,
  output logic [NUM_EVT:0]    ovf_o,
  output logic [31:0]         disp_o,
  output logic                halt_o
);

  perf_state_e state_q, state_d;

  logic             run_en;
  logic [NUM_EVT:0] inc;
  logic [CNT_W-1:0] live [NUM_EVT+1];
  logic [CNT_W-1:0] src  [NUM_EVT+1];
  logic [CNT_W-1:0] sel_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (halt_req_i) state_d = HALTED;
      HALTED:  if (resume_i && !halt_req_i) state_d = RUN;
      CLEAR:   state_d = RUN;
      default: state_d = RUN;
    endcase
    if (clr_i) state_d = CLEAR;
  end

  // clr_i wins over any increment in the same cycle
  assign run_en = (state_q == RUN) && !clr_i;
  assign halt_o = (state_q == HALTED);
  assign inc    = {1'b1, evt_i} & {(NUM_EVT+1){run_en}};

  for (genvar k = 0; k <= NUM_EVT; k++) begin : g_cnt
    perf_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (inc[k]),
      .clr (clr_i),
      .cnt (live[k]),
      .ovf (ovf_o[k])
    );
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] shadow [NUM_EVT+1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k <= NUM_EVT; k++) shadow[k] <= '0;
    end else if (clr_i) begin
      for (int k = 0; k <= NUM_EVT; k++) shadow[k] <= '0;
    end else if (snap_i) begin
      for (int k = 0; k <= NUM_EVT; k++) shadow[k] <= live[k];
    end
  end

  // a read issued with snap_i sees the value being captured
  always_comb begin
    for (int k = 0; k <= NUM_EVT; k++)
      src[k] = snap_i ? live[k] : shadow[k];
  end
`else
  logic unused_snap;
  assign unused_snap = snap_i;

  always_comb begin
    for (int k = 0; k <= NUM_EVT; k++) src[k] = live[k];
  end
`endif

  always_comb begin
    sel_val = '0;
    for (int k = 0; k <= NUM_EVT; k++)
      if (rd_sel_i == RD_SEL_W'(k)) sel_val = src[k];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ack_o  <= 1'b0;
      rd_data_o <= '0;
    end else begin
      rd_ack_o  <= rd_req_i;
      rd_data_o <= rd_req_i ? sel_val : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           disp_o <= '0;
    else if (disp_we_i) disp_o <= disp_data_i;
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench: wrap (a) and saturate (b) 8-bit banks on shared stimulus.
module tb_perf_counter_bank;

  localparam int NE = 4;
  localparam int CW = 8;
`ifdef PERF_SNAPSHOT_EN
  localparam logic [CW-1:0] SNAP_EXP = 8'd50;
`else
  localparam logic [CW-1:0] SNAP_EXP = 8'd70;
`endif

  logic clk = 1'b0;
  logic rst;
  int   tb_cyc    = 0;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   rd_id     = 0;

  perf_counter_bank_if #(.NUM_EVT(NE), .CNT_W(CW)) bus ();

  logic          rd_ack_b;
  logic [CW-1:0] rd_data_b;
  logic [NE:0]   ovf_b;
  logic [31:0]   disp_b;
  logic          halt_b;

  typedef struct {
    logic [CW-1:0] a;
    logic [CW-1:0] b;
    int            cyc;
    int            id;
  } exp_t;

  exp_t sb[$];

  perf_counter_bank #(.NUM_EVT(NE), .CNT_W(CW), .SATURATE(0)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .evt_i       (bus.evt_i),
    .halt_req_i  (bus.halt_req_i),
    .resume_i    (bus.resume_i),
    .clr_i       (bus.clr_i),
    .snap_i      (bus.snap_i),
    .disp_we_i   (bus.disp_we_i),
    .disp_data_i (bus.disp_data_i),
    .rd_req_i    (bus.rd_req_i),
    .rd_sel_i    (bus.rd_sel_i),
    .rd_ack_o    (bus.rd_ack_o),
    .rd_data_o   (bus.rd_data_o),
    .ovf_o       (bus.ovf_o),
    .disp_o      (bus.disp_o),
    .halt_o      (bus.halt_o)
  );

  perf_counter_bank #(.NUM_EVT(NE), .CNT_W(CW), .SATURATE(1)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .evt_i       (bus.evt_i),
    .halt_req_i  (bus.halt_req_i),
    .resume_i    (bus.resume_i),
    .clr_i       (bus.clr_i),
    .snap_i      (bus.snap_i),
    .disp_we_i   (bus.disp_we_i),
    .disp_data_i (bus.disp_data_i),
    .rd_req_i    (bus.rd_req_i),
    .rd_sel_i    (bus.rd_sel_i),
    .rd_ack_o    (rd_ack_b),
    .rd_data_o   (rd_data_b),
    .ovf_o       (ovf_b),
    .disp_o      (disp_b),
    .halt_o      (halt_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tb_cyc++;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // monitor: pops one expected response per ack, flags late/missing acks
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0 && tb_cyc > sb[0].cyc + 1) begin
      e = sb.pop_front();
      chk($sformatf("rd%0d_ack_missing", e.id), 64'(bus.rd_ack_o), 1);
    end
    if (bus.rd_ack_o || rd_ack_b) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 64'({bus.rd_ack_o, rd_ack_b}), 0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("rd%0d_ack", e.id),
            64'({bus.rd_ack_o, rd_ack_b}), 64'(2'b11));
        chk($sformatf("rd%0d_lat", e.id), 64'(tb_cyc - e.cyc), 1);
        chk($sformatf("rd%0d_data_a", e.id), 64'(bus.rd_data_o), 64'(e.a));
        chk($sformatf("rd%0d_data_b", e.id), 64'(rd_data_b), 64'(e.b));
      end
    end
  end

  task automatic issue(input logic [4:0] sel, input logic [CW-1:0] ea,
                       input logic [CW-1:0] eb, input logic snap);
    bus.rd_req_i = 1'b1;
    bus.rd_sel_i = sel;
    bus.snap_i   = snap;
    sb.push_back('{a: ea, b: eb, cyc: tb_cyc, id: rd_id});
    rd_id++;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.rd_req_i = 1'b0;
    bus.rd_sel_i = '0;
    bus.snap_i   = 1'b0;
    @(negedge clk);
    chk("idle_ack", 64'(bus.rd_ack_o), 0);
    chk("idle_data", 64'(bus.rd_data_o), 0);
  endtask

  task automatic clear();
    bus.clr_i = 1'b1;
    @(negedge clk);
    bus.clr_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b0;
    bus.evt_i       = '0;
    bus.halt_req_i  = 1'b0;
    bus.resume_i    = 1'b0;
    bus.clr_i       = 1'b0;
    bus.snap_i      = 1'b0;
    bus.disp_we_i   = 1'b0;
    bus.disp_data_i = '0;
    bus.rd_req_i    = 1'b0;
    bus.rd_sel_i    = '0;
    repeat (2) @(negedge clk);
    chk("rst_halt", 64'(bus.halt_o), 0);
    chk("rst_ovf_a", 64'(bus.ovf_o), 0);
    chk("rst_ovf_b", 64'(ovf_b), 0);
    chk("rst_disp", 64'(bus.disp_o), 0);
    chk("rst_ack", 64'(bus.rd_ack_o), 0);
    chk("rst_data", 64'(bus.rd_data_o), 0);

    // 100 cycles after release, then back-to-back and out-of-range reads
    rst = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    issue(5'd4, 8'd100, 8'd100, 1'b1);
    idle();
    issue(5'd4, 8'd102, 8'd102, 1'b1);
    issue(5'd4, 8'd103, 8'd103, 1'b1);
    idle();
    issue(5'd20, 8'd0, 8'd0, 1'b1);
    idle();

    // halt: 7 counted pulses, 3 ignored, cycle counter frozen at 15
    clear();
    chk("halt_o_run", 64'(bus.halt_o), 0);
    for (int i = 0; i < 7; i++) begin
      bus.evt_i = 4'b0100;
      @(negedge clk);
      bus.evt_i = '0;
      @(negedge clk);
    end
    bus.halt_req_i = 1'b1;
    @(negedge clk);
    bus.halt_req_i = 1'b0;
    chk("halt_o_halted", 64'(bus.halt_o), 1);
    chk("halt_o_halted_b", 64'(halt_b), 1);
    for (int i = 0; i < 3; i++) begin
      bus.evt_i = 4'b0100;
      @(negedge clk);
      bus.evt_i = '0;
      @(negedge clk);
    end
    bus.disp_we_i   = 1'b1;
    bus.disp_data_i = 32'h55AA_0F0F;
    @(negedge clk);
    bus.disp_we_i = 1'b0;
    chk("disp_halted", 64'(bus.disp_o), 64'h55AA_0F0F);
    issue(5'd2, 8'd7, 8'd7, 1'b1);
    idle();
    issue(5'd4, 8'd15, 8'd15, 1'b1);
    idle();
    bus.resume_i   = 1'b1;
    bus.halt_req_i = 1'b1;
    @(negedge clk);
    bus.halt_req_i = 1'b0;
    chk("halt_o_blocked_resume", 64'(bus.halt_o), 1);
    @(negedge clk);
    bus.resume_i = 1'b0;
    chk("halt_o_resumed", 64'(bus.halt_o), 0);
    issue(5'd2, 8'd7, 8'd7, 1'b1);
    idle();

    // 260 pulses: wrap lands on 4, saturate holds 255
    clear();
    bus.evt_i = 4'b0001;
    repeat (260) @(negedge clk);
    bus.evt_i = '0;
    chk("ovf0_a", 64'(bus.ovf_o[0]), 1);
    chk("ovf0_b", 64'(ovf_b[0]), 1);
    chk("ovf_cyc_a", 64'(bus.ovf_o[4]), 1);
    chk("ovf_idle_evts_a", 64'(bus.ovf_o[3:1]), 0);
    issue(5'd0, 8'd4, 8'd255, 1'b1);
    idle();

    // clear beats simultaneous events and halt request
    bus.clr_i      = 1'b1;
    bus.evt_i      = 4'hF;
    bus.halt_req_i = 1'b1;
    @(negedge clk);
    bus.clr_i      = 1'b0;
    bus.evt_i      = '0;
    bus.halt_req_i = 1'b0;
    chk("clr_ovf_a", 64'(bus.ovf_o), 0);
    chk("clr_ovf_b", 64'(ovf_b), 0);
    chk("clr_halt", 64'(bus.halt_o), 0);
    @(negedge clk);
    chk("clr_then_run", 64'(bus.halt_o), 0);
    issue(5'd0, 8'd0, 8'd0, 1'b1);
    issue(5'd1, 8'd0, 8'd0, 1'b1);
    issue(5'd2, 8'd0, 8'd0, 1'b1);
    issue(5'd3, 8'd0, 8'd0, 1'b1);
    issue(5'd4, 8'd4, 8'd4, 1'b1);
    idle();

    bus.disp_we_i   = 1'b1;
    bus.disp_data_i = 32'h0000_007B;
    @(negedge clk);
    bus.disp_we_i = 1'b0;
    chk("disp_a", 64'(bus.disp_o), 123);
    chk("disp_b", 64'(disp_b), 123);
    issue(5'd20, 8'd0, 8'd0, 1'b1);
    idle();

    // snapshot at 50, read without snap at 70
    clear();
    repeat (50) @(negedge clk);
    bus.snap_i = 1'b1;
    @(negedge clk);
    bus.snap_i = 1'b0;
    repeat (19) @(negedge clk);
    issue(5'd4, SNAP_EXP, SNAP_EXP, 1'b0);
    idle();

    // reset lands while a read is pending
    bus.rd_req_i = 1'b1;
    bus.rd_sel_i = 5'd4;
    bus.snap_i   = 1'b1;
    #2 rst = 1'b0;
    #1 chk("midrd_rst_ack", 64'(bus.rd_ack_o), 0);
    @(negedge clk);
    bus.rd_req_i = 1'b0;
    bus.snap_i   = 1'b0;
    chk("midrd_rst_ack_late", 64'({bus.rd_ack_o, rd_ack_b}), 0);
    chk("midrd_rst_disp", 64'(bus.disp_o), 0);
    chk("midrd_rst_data", 64'(bus.rd_data_o), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ack", 64'(bus.rd_ack_o), 0);
    issue(5'd4, 8'd1, 8'd1, 1'b1);
    idle();

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 SHALL have parameter NUM_EVT, default 4: number of event counters (1..16).
REQ-002 SHALL have parameter CNT_W, default 32: width of every counter (8..64).
REQ-003 SHALL have parameter SATURATE, default 0: 1 = saturate at all-ones, 0 = wrap to zero.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port evt_i, input, NUM_EVT: per-event increment strobes (branch taken, conditional branch, conditional success, syscall, ...).
REQ-007 SHALL have port halt_req_i, input, 1: request to freeze all counting.
REQ-008 SHALL have port resume_i, input, 1: leave halted state.
REQ-009 SHALL have port clr_i, input, 1: synchronous clear of all counters and overflow flags.
REQ-010 SHALL have port disp_we_i, input, 1, and port disp_data_i, input, 32: syscall display write.
REQ-011 SHALL have port rd_req_i, input, 1, and port rd_sel_i, input, 5: counter read request and index.
REQ-012 SHALL have port rd_ack_o, output, 1, and port rd_data_o, output, CNT_W: read response.
REQ-013 SHALL have port ovf_o, output, NUM_EVT+1: sticky overflow flags, bit NUM_EVT = cycle counter.
REQ-014 SHALL have port disp_o, output, 32, and port halt_o, output, 1.
REQ-015 SHALL have port snap_i, input, 1: snapshot request (used only per REQ-031).

Function
REQ-016 SHALL implement states RUN, HALTED, CLEAR.
REQ-017 RUN -> HALTED when halt_req_i=1; HALTED -> RUN when resume_i=1 and halt_req_i=0; any state -> CLEAR when clr_i=1; CLEAR -> RUN next cycle unconditionally.
REQ-018 In RUN, cycle counter (index NUM_EVT) SHALL increment by 1 every cycle, including the cycle halt_req_i is first sampled.
REQ-019 In RUN, event counter k SHALL increment by 1 in each cycle evt_i[k]=1.
REQ-020 In HALTED and CLEAR, no counter SHALL increment; halt_o=1 exactly in HALTED.
REQ-021 In CLEAR, all counters and ovf_o SHALL be zero one cycle after clr_i; clr_i has priority over halt_req_i and evt_i.
REQ-022 On increment from all-ones: SATURATE=0 wraps to 0; SATURATE=1 holds all-ones; both set the matching ovf_o bit, which stays set until clr_i or reset.
REQ-023 rd_req_i SHALL produce rd_ack_o=1 for exactly one cycle, on the next cycle, with rd_data_o valid that same cycle; back-to-back requests SHALL be acknowledged every cycle.
REQ-024 rd_sel_i 0..NUM_EVT-1 selects event counters; NUM_EVT selects cycle counter; any other index returns 0 with ack.
REQ-025 Read of a counter incremented in the request cycle SHALL return the pre-increment value.
REQ-026 disp_we_i=1 SHALL load disp_data_i into disp_o next cycle, in every state.
REQ-027 rd_data_o SHALL be 0 when rd_ack_o=0.

Reset
REQ-028 On rst=0, asynchronously: state RUN, all counters 0, ovf_o 0, disp_o 0, halt_o 0, rd_ack_o 0, rd_data_o 0.
REQ-029 Reset asserted mid-read SHALL drop the pending ack; no ack after release.
REQ-030 Counting SHALL resume on the first clock edge after rst rises.

Configuration
REQ-031 With PERF_SNAPSHOT_EN defined: snap_i=1 copies all counters (pre-increment values) into shadow registers in one cycle and reads return shadow values; shadow cleared by reset and clr_i.
REQ-032 Without PERF_SNAPSHOT_EN: no shadow registers, snap_i ignored, reads return live values.

Structure
REQ-033 Package perf_pkg SHALL hold the state enum (RUN, HALTED, CLEAR), default NUM_EVT/CNT_W constants and the read-index width.
REQ-034 Sub-module perf_counter SHALL implement one CNT_W counter with inc, clr, SATURATE and sticky overflow; instantiated NUM_EVT+1 times.

Verification
REQ-035 Release reset, run 100 cycles, read index 4 -> rd_data_o=100 (+/-0 at sampled edge), rd_ack_o one cycle after request.
REQ-036 Pulse evt_i[2] 7 times, halt_req_i, pulse 3 more, resume, read index 2 -> 7; halt_o=1 only while halted.
REQ-037 CNT_W=8, SATURATE=0, 260 pulses on evt_i[0] -> read 4, ovf_o[0]=1; SATURATE=1 -> read 255, ovf_o[0]=1.
REQ-038 clr_i together with evt_i=4'hF and halt_req_i -> all counters 0, ovf_o 0, state RUN next cycle.
REQ-039 disp_we_i with 32'h0000_007B -> disp_o=123 next cycle; read index 20 -> 0 with ack.
REQ-040 With PERF_SNAPSHOT_EN: snap_i at cycle count 50, run 20 more, read index 4 -> 50; without macro -> live value.
